// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, read-only cache controller in front of main memory.
// Serves 32-bit word reads from 4-word (128-bit) lines. A miss fetches the whole
// block, fills the line and returns the requested word.
// Optional build macro CACHE_STATS_EN adds access_count / hit_count outputs.
module dm_cache_ctrl #(
   parameter int INDEX_W  = 10,
   parameter int MEM_WAIT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   input  logic [14:0]   req_addr,
   output logic          ready,
   output logic [31:0]   rdata,
   output logic          rdata_valid,
   output logic          hit,
   output logic          mem_rd,
   output logic [14:0]   mem_addr,
   input  logic [127:0]  mem_block
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]   access_count,
   output logic [31:0]   hit_count
`endif
);

   localparam int TAG_W = 15 - INDEX_W - 2;
   localparam int LINES = 1 << INDEX_W;
   localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

   typedef enum logic [1:0] {IDLE, COMPARE, FETCH, RESPOND} state_t;

   state_t             state_q, state_d;
   logic [14:0]        addr_q, addr_d;
   logic               ready_q, ready_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               rdata_valid_q, rdata_valid_d;
   logic               hit_q, hit_d;
   logic               mem_rd_q, mem_rd_d;
   logic [14:0]        mem_addr_q, mem_addr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Line storage: only the valid vector is reset, tag/data are plain RAM.
   logic [127:0]       data_mem [LINES];
   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [LINES-1:0]   valid_q;
   logic [127:0]       line_data_q;
   logic [TAG_W-1:0]   line_tag_q;

   logic [TAG_W-1:0]   tag_f;
   logic [INDEX_W-1:0] idx_f;
   logic [1:0]         off_f;
   logic [INDEX_W-1:0] req_idx;
   logic               accept;
   logic               cnt_last;
   logic               fill;
   logic               line_hit;

   assign tag_f    = addr_q[14:INDEX_W+2];
   assign idx_f    = addr_q[INDEX_W+1:2];
   assign off_f    = addr_q[1:0];
   assign req_idx  = req_addr[INDEX_W+1:2];

   // ready is high in IDLE and in the RESPOND cycle, so both accept a request.
   assign accept   = req_valid && ((state_q == IDLE) || (state_q == RESPOND));
   assign cnt_last = (cnt_q == CNT_W'(MEM_WAIT - 1));
   assign fill     = (state_q == FETCH) && cnt_last;
   assign line_hit = valid_q[idx_f] && (line_tag_q == tag_f);

   // Line RAM: write on fill, registered read of the requested line at accept.
   always_ff @(posedge clk) begin
      if (fill) begin
         data_mem[idx_f] <= mem_block;
         tag_mem[idx_f]  <= tag_f;
      end
      if (accept) begin
         line_data_q <= data_mem[req_idx];
         line_tag_q  <= tag_mem[req_idx];
      end
   end

   // Valid bits: cleared by reset, set when a fill completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (fill) begin
         valid_q[idx_f] <= 1'b1;
      end
   end

   // Next-state and output logic for the lookup/fetch sequence.
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      ready_d       = ready_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      hit_d         = hit_q;
      mem_rd_d      = mem_rd_q;
      mem_addr_d    = mem_addr_q;
      cnt_d         = cnt_q;
      case (state_q)
         // RESPOND returns to IDLE unless a request is already waiting, in
         // which case it is accepted straight away since ready is high.
         IDLE, RESPOND: begin
            state_d = IDLE;
            if (req_valid) begin
               addr_d  = req_addr;
               ready_d = 1'b0;
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            if (line_hit) begin
               rdata_d       = line_data_q[{off_f, 5'd0} +: 32];
               rdata_valid_d = 1'b1;
               hit_d         = 1'b1;
               ready_d       = 1'b1;
               state_d       = IDLE;
            end else begin
               mem_addr_d = {addr_q[14:2], 2'b00};
               mem_rd_d   = 1'b1;
               cnt_d      = '0;
               state_d    = FETCH;
            end
         end
         FETCH: begin
            if (cnt_last) begin
               rdata_d       = mem_block[{off_f, 5'd0} +: 32];
               rdata_valid_d = 1'b1;
               hit_d         = 1'b0;
               mem_rd_d      = 1'b0;
               ready_d       = 1'b1;
               state_d       = RESPOND;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and output registers; reset aborts any fetch in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         ready_q       <= 1'b1;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         hit_q         <= 1'b0;
         mem_rd_q      <= 1'b0;
         mem_addr_q    <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         ready_q       <= ready_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         hit_q         <= hit_d;
         mem_rd_q      <= mem_rd_d;
         mem_addr_q    <= mem_addr_d;
         cnt_q         <= cnt_d;
      end
   end

   assign ready       = ready_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;
   assign hit         = hit_q;
   assign mem_rd      = mem_rd_q;
   assign mem_addr    = mem_addr_q;

`ifdef CACHE_STATS_EN
   logic [31:0] access_count_q;
   logic [31:0] hit_count_q;

   // Free-running statistics, wrapping at 2**32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         access_count_q <= '0;
         hit_count_q    <= '0;
      end else begin
         if (accept) begin
            access_count_q <= access_count_q + 32'd1;
         end
         if ((state_q == COMPARE) && line_hit) begin
            hit_count_q <= hit_count_q + 32'd1;
         end
      end
   end

   assign access_count = access_count_q;
   assign hit_count    = hit_count_q;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed self-checking bench for dm_cache_ctrl.
// Memory model returns word[a] = 32'hA5A50000 | a for the block at mem_addr.
module tb_dm_cache_ctrl;

   localparam int MEM_WAIT = 2;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic [14:0]   req_addr;
   logic          ready;
   logic [31:0]   rdata;
   logic          rdata_valid;
   logic          hit;
   logic          mem_rd;
   logic [14:0]   mem_addr;
   logic [127:0]  mem_block;
`ifdef CACHE_STATS_EN
   logic [31:0]   access_count;
   logic [31:0]   hit_count;
`endif

   int checks = 0;
   int errors = 0;

   dm_cache_ctrl #(.INDEX_W(10), .MEM_WAIT(MEM_WAIT)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .ready       (ready),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .hit         (hit),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_block   (mem_block)
`ifdef CACHE_STATS_EN
      ,
      .access_count(access_count),
      .hit_count   (hit_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] mem_model(input logic [14:0] a);
      logic [127:0] r;
      logic [14:0]  wa;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         wa = {a[14:2], 2'(i)};
         r[i*32 +: 32] = 32'hA5A50000 | {17'd0, wa};
      end
      return r;
   endfunction

   assign mem_block = mem_model(mem_addr);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One read transaction: checks latency, data, hit flag, fetch activity and pulse width.
   task automatic do_read(input string nm, input logic [14:0] a,
                          input logic [31:0] exp_data, input logic exp_hit);
      int          n;
      int          rd_cycles;
      logic [14:0] ma_seen;
      @(negedge clk);
      req_addr  = a;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n = 1;
      rd_cycles = 0;
      ma_seen = '0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (mem_rd) begin
            rd_cycles++;
            ma_seen = mem_addr;
         end
      end while (!rdata_valid && n < 20);
      $display("READ %s addr=%h rdata=%h hit=%0d lat=%0d mem_rd_cycles=%0d",
               nm, a, rdata, hit, n, rd_cycles);
      check_eq({nm, "_lat"}, 32'(n), exp_hit ? 32'd2 : 32'(2 + MEM_WAIT));
      check_eq({nm, "_data"}, rdata, exp_data);
      check_eq({nm, "_hit"}, {31'd0, hit}, {31'd0, exp_hit});
      check_eq({nm, "_ready"}, {31'd0, ready}, 32'd1);
      check_eq({nm, "_memrd"}, 32'(rd_cycles), exp_hit ? 32'd0 : 32'(MEM_WAIT));
      if (!exp_hit) begin
         check_eq({nm, "_maddr"}, {17'd0, ma_seen}, {17'd0, a[14:2], 2'b00});
      end
      @(posedge clk);
      #1;
      check_eq({nm, "_pulse"}, {31'd0, rdata_valid}, 32'd0);
   endtask

   initial begin
      int n;
      int pulses;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_addr  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_ready", {31'd0, ready}, 32'd1);
      check_eq("rst_rdata", rdata, 32'd0);
      check_eq("rst_rvalid", {31'd0, rdata_valid}, 32'd0);
      check_eq("rst_hit", {31'd0, hit}, 32'd0);
      check_eq("rst_memrd", {31'd0, mem_rd}, 32'd0);
      check_eq("rst_maddr", {17'd0, mem_addr}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Cold miss, same-block hit, then conflict eviction on index 1.
      do_read("t1_miss", 15'h0005, 32'hA5A50005, 1'b0);
      do_read("t2_hit",  15'h0007, 32'hA5A50007, 1'b1);
      do_read("t3_miss", 15'h1004, 32'hA5A51004, 1'b0);
      do_read("t3_evict", 15'h0004, 32'hA5A50004, 1'b0);
`ifdef CACHE_STATS_EN
      $display("STATS access_count=%0d hit_count=%0d", access_count, hit_count);
      check_eq("stat_acc", access_count, 32'd4);
      check_eq("stat_hit", hit_count, 32'd1);
`endif

      // Top of the address space.
      do_read("top_miss", 15'h7FFF, 32'hA5A57FFF, 1'b0);
      do_read("top_hit",  15'h7FFC, 32'hA5A57FFC, 1'b1);

      // Reset two cycles into a miss for 0x0008.
      @(negedge clk);
      req_addr  = 15'h0008;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("t4_memrd_pre", {31'd0, mem_rd}, 32'd1);
      rst = 1'b1;
      #1;
      check_eq("t4_memrd_abort", {31'd0, mem_rd}, 32'd0);
      check_eq("t4_ready_abort", {31'd0, ready}, 32'd1);
      pulses = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (rdata_valid) pulses++;
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (rdata_valid) pulses++;
      end
      $display("ABORT addr=0008 pulses=%0d mem_rd=%0d", pulses, mem_rd);
      check_eq("t4_no_pulse", 32'(pulses), 32'd0);
      do_read("t4_refetch", 15'h0008, 32'hA5A50008, 1'b0);

      // Request held during an outstanding miss.
      @(negedge clk);
      req_addr  = 15'h0020;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_addr = 15'h0010;
      n = 1;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!rdata_valid && n < 20);
      $display("HELD first addr=0020 rdata=%h lat=%0d ready=%0d", rdata, n, ready);
      check_eq("t5_lat1", 32'(n), 32'(2 + MEM_WAIT));
      check_eq("t5_data1", rdata, 32'hA5A50020);
      check_eq("t5_ready1", {31'd0, ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check_eq("t5_accepted", {31'd0, ready}, 32'd0);
      n = 1;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!rdata_valid && n < 20);
      $display("HELD second addr=0010 rdata=%h lat=%0d hit=%0d", rdata, n, hit);
      check_eq("t5_lat2", 32'(n), 32'(2 + MEM_WAIT));
      check_eq("t5_data2", rdata, 32'hA5A50010);
      check_eq("t5_hit2", {31'd0, hit}, 32'd0);
      pulses = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (rdata_valid) pulses++;
      end
      check_eq("t5_once", 32'(pulses), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Direct-mapped, read-only cache controller that sits directly upstream of main memory and serves 32-bit word reads from the CPU side. The cache holds 4-word (128-bit) blocks, word-addressed with a 15-bit address. On a miss it presents the block-aligned address to main memory, waits a fixed number of cycles for the registered 128-bit block output, fills the line and returns the requested word.

Parameters:
INDEX_W, 10, index width; the cache holds 2**INDEX_W lines. Tag width is TAG_W = 15-INDEX_W-2.
MEM_WAIT, 2, cycles the fetch is held before mem_block is sampled; must be at least 1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  CPU read request
req_addr  in  15  CPU word address: [14:2+INDEX_W]=tag, [INDEX_W+1:2]=index, [1:0]=word offset
ready  out  1  controller idle; a request is accepted only when ready=1
rdata  out  32  returned word
rdata_valid  out  1  one-cycle pulse; rdata is valid in that cycle
hit  out  1  qualifies rdata_valid: 1=hit, 0=serviced by a fill
mem_rd  out  1  high throughout a fetch
mem_addr  out  15  block-aligned fetch address {tag,index,2'b00}, stable while mem_rd=1
mem_block  in  128  block from memory; word i is in bits [32i+31:32i]

Behaviour:
- Storage: valid bit, TAG_W-bit tag and 128-bit data per line. Only the valid vector is reset; tag and data arrays are not.
- Reset (async) values:
  - state=IDLE, all valid bits = 0.
  - ready=1, rdata=0, rdata_valid=0, hit=0, mem_rd=0, mem_addr=0.
- FSM states: IDLE, COMPARE, FETCH, RESPOND.
- IDLE: ready=1. If req_valid is high at an edge, latch req_addr, go to COMPARE, and drop ready. With req_valid=0, remain in IDLE.
- COMPARE: look up the latched index.
  - Hit (valid and tag match): at the next edge, register rdata = line word[offset], rdata_valid=1, hit=1; go to IDLE.
  - Miss: at the next edge, set mem_addr={tag,index,00}, mem_rd=1, clear the wait counter; go to FETCH.
- FETCH: the counter increments each cycle. At the edge where counter==MEM_WAIT-1:
  - write mem_block to the line, write the tag, set the valid bit;
  - register rdata = mem_block word[offset];
  - drop mem_rd; go to RESPOND.
- RESPOND: rdata_valid=1 and hit=0 for this one cycle, then go to IDLE.
- rdata_valid is high for exactly one cycle per request. rdata holds its last value otherwise.
- Latency, counted from the accepting edge to rdata_valid high:
  - hit: 2 edges;
  - miss: 2+MEM_WAIT edges.
  - ready returns high in the same cycle rdata_valid is high; a new request may be accepted at the following edge.
- req_valid while ready=0: ignored; the requester must hold it.
- Conflict miss: the fill overwrites the line unconditionally. There is no write-back.
- All 15-bit addresses are legal, including 0x7FFF; there is no range check.
- rst during FETCH: abort immediately. The line's valid bit is left 0, mem_rd drops, and no rdata_valid is produced.
- Back-to-back requests to the same block: the second request hits.

Optional Feature:
CACHE_STATS_EN:
- Defined:
  - adds outputs access_count[31:0] and hit_count[31:0];
  - access_count increments on every accepted request; hit_count increments on every hit response;
  - both reset to 0, wrap at 2**32, no saturation.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Memory preloaded with word[a]=32'hA5A50000|a. After reset, read 0x0005 -> miss. mem_rd high with mem_addr=0x0004 for MEM_WAIT cycles; rdata=32'hA5A50005, hit=0, 2+MEM_WAIT=4 edges after accept.
2. Immediately read 0x0007 -> hit, rdata=32'hA5A50007, rdata_valid 2 edges after accept, mem_rd stays 0.
3. Read 0x1004 (index 1, tag 1) after test 1 -> miss, mem_addr=0x1004, rdata=32'hA5A51004. Then read 0x0004 -> miss again (conflict eviction), rdata=32'hA5A50004.
4. Assert rst two cycles into a miss for 0x0008. mem_rd drops, rdata_valid stays 0. A read of 0x0008 after release -> miss, rdata=32'hA5A50008.
5. Hold req_valid with 0x0010 during an outstanding miss -> not accepted until ready=1; then serviced once, exactly one rdata_valid pulse.
6. CACHE_STATS_EN defined, run tests 1-3 -> access_count=4, hit_count=1.
